// File: rtl/servo_pkg.sv
// servo_pkg: shared types and constants for the servo sequencer.
// Holds the FSM state enum, the position/channel widths, the default timing
// constants and the position-to-ticks helper.
package servo_pkg;

    typedef enum logic [1:0] {
        StDisabled = 2'd0,
        StCommit   = 2'd1,
        StRun      = 2'd2
    } state_t;

    localparam int unsigned POS_W = 8;
    localparam int unsigned CH_W  = 4;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_TICK_DIV    = 50;
    localparam int unsigned DEF_FRAME_TICKS = 20000;
    localparam int unsigned DEF_MIN_TICKS   = 1000;
    localparam int unsigned DEF_POS_SHIFT   = 2;
    localparam int unsigned DEF_CENTER_POS  = 128;
    localparam int unsigned DEF_SLEW_STEP   = 4;

    // Pulse width in ticks, evaluated at 32 bits so it cannot wrap.
    function automatic logic [31:0] pulse_ticks(input logic [POS_W-1:0] pos,
                                                input int unsigned min_ticks,
                                                input int unsigned shift);
        return min_ticks + ({24'd0, pos} << shift);
    endfunction

endpackage

// File: rtl/servo_sequencer_tick_gen.sv
// servo_tick_gen: TICK_DIV prescaler producing a one-clock tick.
// While i_clear is high the counter is held at zero and no tick is produced,
// so the first tick after release arrives TICK_DIV clocks later.
module servo_tick_gen #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Prescaler counter: wraps at TICK_DIV-1, synchronously cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/servo_sequencer.sv
// servo_sequencer: multi-channel servo PWM frame generator.
// Commands load per-channel shadow positions; each frame COMMIT copies them to
// the active positions that set the pulse widths. Defining SERVO_SLEW_EN makes
// COMMIT step active toward shadow by at most SLEW_STEP instead of copying.
module servo_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int unsigned MIN_TICKS   = DEF_MIN_TICKS,
    parameter int unsigned POS_SHIFT   = DEF_POS_SHIFT,
    parameter int unsigned CENTER_POS  = DEF_CENTER_POS,
    parameter int unsigned SLEW_STEP   = DEF_SLEW_STEP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_channel,
    input  logic [POS_W-1:0]  cmd_position,
    output logic [NUM_CH-1:0] pwm,
    output logic              frame_start
);
    localparam int unsigned WW = $clog2(FRAME_TICKS + 1);
    localparam logic [WW-1:0] FRAME_LAST = WW'(FRAME_TICKS - 1);
    localparam logic [WW-1:0] FRAME_FULL = WW'(FRAME_TICKS);
    localparam logic [POS_W-1:0] CENTER = POS_W'(CENTER_POS);

    if (NUM_CH < 1 || NUM_CH > 16 || SLEW_STEP > 255) begin : g_param_check
        $error("servo_sequencer: parameter out of range");
    end

    state_t             r_state, w_state_d;
    logic [WW-1:0]      r_frame_cnt, w_frame_cnt_d;
    logic [POS_W-1:0]   r_shadow [NUM_CH];
    logic [POS_W-1:0]   r_active [NUM_CH];
    logic [POS_W-1:0]   w_active_d [NUM_CH];
    logic [31:0]        w_raw [NUM_CH];
    logic [WW-1:0]      w_width [NUM_CH];
    logic [NUM_CH-1:0]  w_full_next;
    logic [NUM_CH-1:0]  r_pwm, w_pwm_d;
    logic               w_tick, w_tick_clr, w_accept;

    servo_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_tick_clr),
        .o_tick  (w_tick)
    );

    assign w_tick_clr = (r_state != StRun) || !enable;
    assign cmd_ready  = !reset && (r_state != StCommit);
    assign w_accept   = cmd_valid && cmd_ready;
    assign pwm        = r_pwm;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= StDisabled;
        else       r_state <= w_state_d;
    end

    // Next state and frame_start; enable low overrides every transition.
    always_comb begin
        w_state_d   = r_state;
        frame_start = 1'b0;
        case (r_state)
            StDisabled: w_state_d = StCommit;
            StCommit: begin
                w_state_d   = StRun;
                frame_start = 1'b1;
            end
            StRun: if (w_tick && (r_frame_cnt == FRAME_LAST)) w_state_d = StCommit;
            default: w_state_d = StDisabled;
        endcase
        if (!enable) w_state_d = StDisabled;
    end

    // Frame tick counter: zero outside RUN, wraps on the last tick of a frame.
    always_comb begin
        w_frame_cnt_d = r_frame_cnt;
        if ((r_state != StRun) || !enable) begin
            w_frame_cnt_d = '0;
        end else if (w_tick) begin
            w_frame_cnt_d = (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
    end

    // Frame tick counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_frame_cnt <= '0;
        else       r_frame_cnt <= w_frame_cnt_d;
    end

    // Value active takes at COMMIT, plus widths clamped to the frame length.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef SERVO_SLEW_EN
            if (r_shadow[ch] > r_active[ch]) begin
                w_active_d[ch] = ((r_shadow[ch] - r_active[ch]) > POS_W'(SLEW_STEP))
                               ? r_active[ch] + POS_W'(SLEW_STEP) : r_shadow[ch];
            end else begin
                w_active_d[ch] = ((r_active[ch] - r_shadow[ch]) > POS_W'(SLEW_STEP))
                               ? r_active[ch] - POS_W'(SLEW_STEP) : r_shadow[ch];
            end
`else
            w_active_d[ch] = r_shadow[ch];
`endif
            w_raw[ch]       = pulse_ticks(r_active[ch], MIN_TICKS, POS_SHIFT);
            w_width[ch]     = (w_raw[ch] >= FRAME_TICKS) ? FRAME_FULL : w_raw[ch][WW-1:0];
            w_full_next[ch] = pulse_ticks(w_active_d[ch], MIN_TICKS, POS_SHIFT) >= FRAME_TICKS;
        end
    end

    // Shadow loads on accept; out-of-range channels match no entry and are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) r_shadow[ch] <= CENTER;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_accept && (cmd_channel == CH_W'(ch))) r_shadow[ch] <= cmd_position;
            end
        end
    end

    // Active positions update only at COMMIT, all channels together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) r_active[ch] <= CENTER;
        end else if (r_state == StCommit) begin
            for (int ch = 0; ch < NUM_CH; ch++) r_active[ch] <= w_active_d[ch];
        end
    end

    // PWM next value; a full-frame channel stays high through COMMIT so the wrap is glitch-free.
    always_comb begin
        w_pwm_d = '0;
        if (enable) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (r_state == StRun)         w_pwm_d[ch] = r_frame_cnt < w_width[ch];
                else if (r_state == StCommit) w_pwm_d[ch] = w_full_next[ch];
            end
        end
    end

    // Registered PWM outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_pwm <= '0;
        else       r_pwm <= w_pwm_d;
    end

endmodule
